sos_detect: RTL and testbench

SOS_DETECT -- requirements
Module: sos_detect

---
 rtl/morse_pkg.sv | 40 ++++
 rtl/sos_detect_gap_timer.sv | 26 ++
 rtl/sos_detect.sv | 66 ++++++
 tb/tb_sos_detect.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types for the SOS detector: FSM state enum, character event codes,
// and the event classifier and next-state function used by the top.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GOT_S  = 2'd1,
    GOT_SO = 2'd2
  } sos_state_t;

  typedef logic [1:0] char_t;

  localparam char_t CH_NONE = 2'd0;
  localparam char_t CH_S    = 2'd1;
  localparam char_t CH_O    = 2'd2;
  localparam char_t CH_ERR  = 2'd3;

  function automatic char_t classify(input logic s, input logic o);
    char_t ch;
    ch = CH_NONE;
    if (s && o)  ch = CH_ERR;
    else if (s)  ch = CH_S;
    else if (o)  ch = CH_O;
    return ch;
  endfunction

  // An S always (re)starts a sequence, so a completing S doubles as the next first S.
  function automatic sos_state_t sos_next(input sos_state_t cur, input char_t ch);
    sos_state_t nxt;
    nxt = cur;
    case (ch)
      CH_S:    nxt = GOT_S;
      CH_O:    nxt = (cur == GOT_S) ? GOT_SO : IDLE;
      CH_ERR:  nxt = IDLE;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sos_detect_gap_timer.sv
// Idle-gap timer: counts cycles while run is high and clear is low; expired
// is high for the one cycle the count equals TIMEOUT_CYCLES, then it wraps to 0.
module gap_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] count;

  assign expired = (count == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   count <= '0;
    else if (clear || expired) count <= '0;
    else if (run)              count <= count + W'(1);
  end

endmodule

// File: rtl/sos_detect.sv
// SOS sequence detector over S/O character events with a saturating hit counter.
// Optional idle-gap abandonment of partial sequences is enabled by SOS_TIMEOUT_EN.
module sos_detect
  import morse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_cb,
  input  logic             s_is,
  input  logic             o_cb,
  input  logic             o_is,
  output logic             busy,
  output logic             found,
  output logic [CNT_W-1:0] sos_count,
  output logic [1:0]       last_char
);

  sos_state_t state;
  sos_state_t state_nxt;
  char_t      ch;
  logic       timeout;
  logic       hit;

  assign ch  = classify(s_is, o_is);
  assign hit = (state == GOT_SO) && (ch == CH_S);

`ifdef SOS_TIMEOUT_EN
  // Any character activity, or sitting in IDLE, keeps the gap count at zero.
  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  ((ch != CH_NONE) || s_cb || o_cb || (state == IDLE)),
    .run    (state != IDLE),
    .expired(timeout)
  );
`else
  logic unused_timer_inputs;
  assign unused_timer_inputs = ^{s_cb, o_cb, TIMEOUT_CYCLES[0]};
  assign timeout = 1'b0;
`endif

  // A real event always wins over a coincident timer expiry.
  assign state_nxt = ((ch == CH_NONE) && timeout) ? IDLE : sos_next(state, ch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      found     <= 1'b0;
      sos_count <= '0;
      last_char <= CH_NONE;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      found <= hit;
      if (hit && (sos_count != '1)) sos_count <= sos_count + CNT_W'(1);
      if (ch != CH_NONE) last_char <= ch;
    end
  end

endmodule

// File: tb/tb_sos_detect.sv
// Directed bench for sos_detect: default instance plus a TIMEOUT_CYCLES=10,
// CNT_W=2 instance driven by the same stimulus. Honors SOS_TIMEOUT_EN.
module tb_sos_detect;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic s_cb = 1'b0, s_is = 1'b0, o_cb = 1'b0, o_is = 1'b0;

  logic       busy, found;
  logic [7:0] sos_count;
  logic [1:0] last_char;
  logic       busy2, found2;
  logic [1:0] sos_count2;
  logic [1:0] last_char2;

  int checks = 0;
  int errors = 0;
  int found_pulses = 0;
  int found2_pulses = 0;

  sos_detect dut (
    .clk(clk), .rst(rst), .s_cb(s_cb), .s_is(s_is), .o_cb(o_cb), .o_is(o_is),
    .busy(busy), .found(found), .sos_count(sos_count), .last_char(last_char)
  );

  sos_detect #(.TIMEOUT_CYCLES(10), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .s_cb(s_cb), .s_is(s_is), .o_cb(o_cb), .o_is(o_is),
    .busy(busy2), .found(found2), .sos_count(sos_count2), .last_char(last_char2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (found)  found_pulses++;
    if (found2) found2_pulses++;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s_is = 1'b0; o_is = 1'b0; s_cb = 1'b0; o_cb = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    found_pulses = 0;
    found2_pulses = 0;
  endtask

  task automatic pulse(input logic s, input logic o);
    @(negedge clk);
    s_is = s; o_is = o;
    @(negedge clk);
    s_is = 1'b0; o_is = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, found, sos_count, last_char} !== 12'd0) begin
      errors++;
      $display("[TB] FAIL reset_dut got busy=%0b found=%0b cnt=%0d last=%0d expected all 0", busy, found, sos_count, last_char);
    end
    checks++;
    if ({busy2, found2, sos_count2, last_char2} !== 6'd0) begin
      errors++;
      $display("[TB] FAIL reset_dut2 got busy=%0b found=%0b cnt=%0d last=%0d expected all 0", busy2, found2, sos_count2, last_char2);
    end
  endtask

  task automatic test_spaced_sos();
    do_reset();
    pulse(1, 0);
    checks++;
    if (busy !== 1'b1 || last_char !== 2'd1) begin
      errors++;
      $display("[TB] FAIL spaced_after_s got busy=%0b last=%0d expected busy=1 last=1", busy, last_char);
    end
    repeat (19) @(negedge clk);
    pulse(0, 1);
    checks++;
    if (busy !== 1'b1 || last_char !== 2'd2 || found !== 1'b0) begin
      errors++;
      $display("[TB] FAIL spaced_after_o got busy=%0b last=%0d found=%0b expected 1 2 0", busy, last_char, found);
    end
    repeat (19) @(negedge clk);
    pulse(1, 0);
    checks++;
    if (found !== 1'b1 || sos_count !== 8'd1 || busy !== 1'b1 || last_char !== 2'd1) begin
      errors++;
      $display("[TB] FAIL spaced_found got found=%0b cnt=%0d busy=%0b last=%0d expected 1 1 1 1", found, sos_count, busy, last_char);
    end
    @(negedge clk);
    checks++;
    if (found !== 1'b0 || sos_count !== 8'd1 || busy !== 1'b1 || found_pulses != 1) begin
      errors++;
      $display("[TB] FAIL spaced_after got found=%0b cnt=%0d busy=%0b pulses=%0d expected 0 1 1 1", found, sos_count, busy, found_pulses);
    end
  endtask

  task automatic test_overlap();
    do_reset();
    pulse(1, 0); pulse(0, 1); pulse(1, 0); pulse(0, 1); pulse(1, 0);
    @(negedge clk);
    checks++;
    if (found_pulses != 2 || sos_count !== 8'd2 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overlap got pulses=%0d cnt=%0d busy=%0b expected 2 2 1", found_pulses, sos_count, busy);
    end
  endtask

  task automatic test_error_event();
    do_reset();
    pulse(1, 0); pulse(0, 1);
    pulse(1, 1);
    checks++;
    if (busy !== 1'b0 || last_char !== 2'd3 || found !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_event got busy=%0b last=%0d found=%0b expected 0 3 0", busy, last_char, found);
    end
    @(negedge clk);
    checks++;
    if (found_pulses != 0 || sos_count !== 8'd0 || last_char !== 2'd3) begin
      errors++;
      $display("[TB] FAIL err_hold got pulses=%0d cnt=%0d last=%0d expected 0 0 3", found_pulses, sos_count, last_char);
    end
    // An O from IDLE must not start anything.
    pulse(0, 1);
    checks++;
    if (busy !== 1'b0 || last_char !== 2'd2) begin
      errors++;
      $display("[TB] FAIL o_from_idle got busy=%0b last=%0d expected 0 2", busy, last_char);
    end
  endtask

  task automatic test_timeout();
    logic exp_busy;
    logic exp_found;
`ifdef SOS_TIMEOUT_EN
    exp_busy  = 1'b0;
    exp_found = 1'b0;
`else
    exp_busy  = 1'b1;
    exp_found = 1'b1;
`endif
    do_reset();
    pulse(1, 0);
    repeat (5) @(negedge clk);
    checks++;
    if (busy2 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_early got busy=%0b expected 1", busy2);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (busy2 !== exp_busy || last_char2 !== 2'd1) begin
      errors++;
      $display("[TB] FAIL timeout_idle got busy=%0b last=%0d expected %0b 1", busy2, last_char2, exp_busy);
    end
    pulse(0, 1); pulse(1, 0);
    @(negedge clk);
    checks++;
    if ((found2_pulses != 0) !== exp_found || busy2 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_os got pulses=%0d busy=%0b expected found=%0b busy=1", found2_pulses, busy2, exp_found);
    end
    // A character in progress keeps the partial sequence alive.
    do_reset();
    pulse(1, 0);
    @(negedge clk);
    s_cb = 1'b1;
    repeat (15) @(negedge clk);
    s_cb = 1'b0;
    checks++;
    if (busy2 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_cb_hold got busy=%0b expected 1", busy2);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    pulse(1, 0);
    for (int i = 0; i < 5; i++) begin
      pulse(0, 1);
      pulse(1, 0);
    end
    @(negedge clk);
    checks++;
    if (sos_count2 !== 2'd3 || found2_pulses != 5) begin
      errors++;
      $display("[TB] FAIL saturate got cnt=%0d pulses=%0d expected 3 5", sos_count2, found2_pulses);
    end
    checks++;
    if (sos_count !== 8'd5 || found_pulses != 5) begin
      errors++;
      $display("[TB] FAIL count_wide got cnt=%0d pulses=%0d expected 5 5", sos_count, found_pulses);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse(1, 0); pulse(1, 0); pulse(0, 1); pulse(1, 0);
    pulse(0, 1);
    checks++;
    if (busy !== 1'b1 || sos_count !== 8'd1 || last_char !== 2'd2) begin
      errors++;
      $display("[TB] FAIL pre_reset got busy=%0b cnt=%0d last=%0d expected 1 1 2", busy, sos_count, last_char);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, found, sos_count, last_char} !== 12'd0 || {busy2, found2, sos_count2, last_char2} !== 6'd0) begin
      errors++;
      $display("[TB] FAIL async_reset got busy=%0b cnt=%0d last=%0d expected all 0", busy, sos_count, last_char);
    end
    @(negedge clk);
    rst = 1'b0;
    found_pulses = 0;
    pulse(1, 0);
    checks++;
    if (busy !== 1'b1 || found !== 1'b0 || last_char !== 2'd1 || sos_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL post_reset_s got busy=%0b found=%0b last=%0d cnt=%0d expected 1 0 1 0", busy, found, last_char, sos_count);
    end
    pulse(0, 1); pulse(1, 0);
    checks++;
    if (found !== 1'b1 || sos_count !== 8'd1) begin
      errors++;
      $display("[TB] FAIL post_reset_sos got found=%0b cnt=%0d expected 1 1", found, sos_count);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_spaced_sos();
    test_overlap();
    test_error_event();
    test_timeout();
    test_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
